pixel_stream_feeder: RTL and testbench

Frame-read front end for the sorting datapath. It reads a frame of 24-bit RGB pixels from a synchronous single-port pixel RAM and presents them one per cycle as `index_pixel` to the pixel classifier (`pixel_in_compare`) and its downstream accumulators. Transfers use a valid/ready handshake, and backpressure is absorbed by a small internal buffer. A `start` pulse launches one frame; a `done` pulse marks its end.

---
 rtl/pixel_stream_feeder_if.sv | 21 ++
 rtl/pixel_stream_feeder.sv | 72 +++++++
 tb/tb_pixel_stream_feeder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_feeder_if.sv
// pixel_stream_feeder_if: RAM read port, pixel valid/ready stream and frame control.
interface pixel_stream_feeder_if #(parameter int ADDR_W = 10);
  logic              start;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_rd_data;
  logic [23:0]       index_pixel;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  logic              busy;
  logic              done;
  modport master (
    input  start, mem_rd_data, pix_ready,
    output mem_rd_en, mem_addr, index_pixel, pix_valid, pix_last, busy, done
  );
  modport slave (
    output start, mem_rd_data, pix_ready,
    input  mem_rd_en, mem_addr, index_pixel, pix_valid, pix_last, busy, done
  );
endinterface

// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder: reads a frame from pixel RAM into a 4-entry FIFO and streams it out.
module pixel_stream_feeder #(
  parameter int NUM_PIXELS = 1024,
  parameter int ADDR_W     = 10
) (
  input logic                    clk,
  input logic                    rst,
  pixel_stream_feeder_if.master  bus
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] NPIX = CW'(NUM_PIXELS);
  localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t        r_state;
  logic [CW-1:0] r_rd_addr;
  logic [CW-1:0] r_xfer;
  logic          r_rd_d;
  logic [23:0]   r_fifo [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_count;
  logic [23:0]   r_hold;
  logic          w_valid;
  logic          w_rd_en;
  logic          w_pop;
  logic          w_last_xfer;
  // Issue only while the FIFO can absorb every outstanding read, so nothing is dropped.
  always_comb begin
    w_valid     = r_count != 3'd0;
    w_rd_en     = (r_state == RUN) && (r_rd_addr < NPIX) && ((r_count + {2'b0, r_rd_d}) < 3'd4);
    w_pop       = w_valid && bus.pix_ready;
    w_last_xfer = w_pop && (r_xfer == LAST);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_addr <= '0;
      r_xfer    <= '0;
      r_rd_d    <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_hold    <= '0;
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
    end else begin
      r_rd_d  <= w_rd_en;
      r_count <= r_count + {2'b0, r_rd_d} - {2'b0, w_pop};
      if (w_rd_en) r_rd_addr <= r_rd_addr + CW'(1);
      if (r_rd_d) begin
        r_fifo[r_wr_ptr] <= bus.mem_rd_data;
        r_wr_ptr         <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_hold   <= r_fifo[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 2'd1;
        r_xfer   <= r_xfer + CW'(1);
      end
      if (r_state != RUN) begin
        r_rd_addr <= '0;
        r_xfer    <= '0;
      end
      r_state <= (r_state == RUN) ? (w_last_xfer ? FIN : RUN) : (bus.start ? RUN : IDLE);
    end
  end
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_addr    = r_rd_addr[ADDR_W-1:0];
  assign bus.index_pixel = w_valid ? r_fifo[r_rd_ptr] : r_hold;
  assign bus.pix_valid   = w_valid;
  assign bus.pix_last    = w_valid && (r_xfer == LAST);
  assign bus.busy        = r_state == RUN;
  assign bus.done        = r_state == FIN;
endmodule

// File: tb/tb_pixel_stream_feeder.sv
// tb_pixel_stream_feeder: directed scenarios against a 4-pixel frame with a 1-cycle RAM model.
module tb_pixel_stream_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pixel_stream_feeder_if #(.ADDR_W(2)) bus ();
  pixel_stream_feeder #(.NUM_PIXELS(4), .ADDR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [23:0] ram [4] = '{24'h010100, 24'h080008, 24'h401810, 24'hE1191C};
  initial bus.mem_rd_data = '0;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
  int checks = 0;
  int errors = 0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.start = 1'b0;
    bus.pix_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic test_reset();
    bus.start = 1'b0;
    bus.pix_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_rd_en, bus.mem_addr, bus.index_pixel, bus.pix_valid, bus.pix_last, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd_en=%b addr=%h pix=%h v=%b l=%b busy=%b done=%b exp all 0",
               bus.mem_rd_en, bus.mem_addr, bus.index_pixel, bus.pix_valid, bus.pix_last, bus.busy, bus.done);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got v=%b busy=%b rd_en=%b exp 0 0 0", bus.pix_valid, bus.busy, bus.mem_rd_en);
    end
  endtask
  task automatic test_streaming();
    do_reset();
    bus.pix_ready = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.pix_valid !== (c >= 3 && c <= 6)) begin
        errors++;
        $display("FAIL stream_valid c=%0d got %b exp %b", c, bus.pix_valid, (c >= 3 && c <= 6));
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (bus.index_pixel !== ram[c-3]) begin
          errors++;
          $display("FAIL stream_pixel c=%0d got %h exp %h", c, bus.index_pixel, ram[c-3]);
        end
      end
      checks++;
      if (bus.pix_last !== (c == 6) || bus.done !== (c == 7) || bus.busy !== (c >= 1 && c <= 6)) begin
        errors++;
        $display("FAIL stream_ctrl c=%0d got last=%b done=%b busy=%b exp %b %b %b", c,
                 bus.pix_last, bus.done, bus.busy, (c == 6), (c == 7), (c >= 1 && c <= 6));
      end
      checks++;
      if (bus.mem_rd_en !== (c >= 1 && c <= 4) || (bus.mem_rd_en === 1'b1 && bus.mem_addr !== 2'(c - 1))) begin
        errors++;
        $display("FAIL stream_read c=%0d got rd_en=%b addr=%0d exp rd_en=%b addr=%0d", c,
                 bus.mem_rd_en, bus.mem_addr, (c >= 1 && c <= 4), c - 1);
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    bus.pix_ready = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      bus.start = 1'b0;
      bus.pix_ready = (c >= 10);
      checks++;
      if (bus.mem_rd_en !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL bp_rd_en c=%0d got %b exp %b", c, bus.mem_rd_en, (c >= 1 && c <= 4));
      end
      if (c >= 3 && c <= 13) begin
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.index_pixel !== ((c <= 9) ? ram[0] : ram[c-10])) begin
          errors++;
          $display("FAIL bp_pixel c=%0d got v=%b pix=%h exp v=1 pix=%h", c, bus.pix_valid,
                   bus.index_pixel, (c <= 9) ? ram[0] : ram[c-10]);
        end
      end
      checks++;
      if (bus.done !== (c == 14) || bus.pix_last !== (c == 13)) begin
        errors++;
        $display("FAIL bp_done c=%0d got done=%b last=%b exp %b %b", c, bus.done, bus.pix_last, (c == 14), (c == 13));
      end
    end
  endtask
  task automatic test_alternating();
    logic [23:0] got [4];
    int n = 0;
    int dones = 0;
    do_reset();
    bus.pix_ready = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      bus.start = 1'b0;
      bus.pix_ready = c[0];
      if (bus.done === 1'b1) dones++;
      if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
        checks++;
        if (bus.pix_last !== (n == 3)) begin
          errors++;
          $display("FAIL alt_last xfer=%0d got %b exp %b", n, bus.pix_last, (n == 3));
        end
        if (n < 4) got[n] = bus.index_pixel;
        n++;
      end
    end
    checks++;
    if (n != 4 || dones != 1) begin
      errors++;
      $display("FAIL alt_count got xfers=%0d dones=%0d exp 4 1", n, dones);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== ram[i]) begin
        errors++;
        $display("FAIL alt_order i=%0d got %h exp %h", i, got[i], ram[i]);
      end
    end
  endtask
  task automatic test_start_busy();
    int dones = 0;
    int reads = 0;
    do_reset();
    bus.pix_ready = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.start = (c == 4);
      if (bus.done === 1'b1) dones++;
      if (bus.mem_rd_en === 1'b1) begin
        reads++;
        checks++;
        if (bus.mem_addr !== 2'(c - 1)) begin
          errors++;
          $display("FAIL sb_addr c=%0d got %0d exp %0d", c, bus.mem_addr, c - 1);
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.index_pixel !== ram[c-3]) begin
          errors++;
          $display("FAIL sb_pixel c=%0d got v=%b pix=%h exp v=1 pix=%h", c, bus.pix_valid, bus.index_pixel, ram[c-3]);
        end
      end
    end
    checks++;
    if (dones != 1 || reads != 4) begin
      errors++;
      $display("FAIL sb_count got dones=%0d reads=%0d exp 1 4", dones, reads);
    end
  endtask
  task automatic test_reset_midframe();
    do_reset();
    bus.pix_ready = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      bus.start = 1'b0;
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_rd_en, bus.mem_addr, bus.index_pixel, bus.pix_valid, bus.pix_last, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL mid_reset got rd_en=%b addr=%h pix=%h v=%b l=%b busy=%b done=%b exp all 0",
               bus.mem_rd_en, bus.mem_addr, bus.index_pixel, bus.pix_valid, bus.pix_last, bus.busy, bus.done);
    end
    step();
    rst = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 2'd0) begin
      errors++;
      $display("FAIL mid_restart_read got rd_en=%b addr=%0d exp 1 0", bus.mem_rd_en, bus.mem_addr);
    end
    step();
    step();
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.index_pixel !== 24'h010100) begin
      errors++;
      $display("FAIL mid_restart_pixel got v=%b pix=%h exp 1 010100", bus.pix_valid, bus.index_pixel);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.pix_ready = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      checks++;
      if (bus.mem_rd_en !== ((c >= 1 && c <= 4) || (c >= 8 && c <= 11))) begin
        errors++;
        $display("FAIL b2b_rd_en c=%0d got %b exp %b", c, bus.mem_rd_en, ((c >= 1 && c <= 4) || (c >= 8 && c <= 11)));
      end
      if ((c >= 3 && c <= 6) || (c >= 10 && c <= 13)) begin
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.index_pixel !== ram[(c < 7) ? c - 3 : c - 10]) begin
          errors++;
          $display("FAIL b2b_pixel c=%0d got v=%b pix=%h exp v=1 pix=%h", c, bus.pix_valid,
                   bus.index_pixel, ram[(c < 7) ? c - 3 : c - 10]);
        end
      end
      checks++;
      if (bus.done !== (c == 7 || c == 14)) begin
        errors++;
        $display("FAIL b2b_done c=%0d got %b exp %b", c, bus.done, (c == 7 || c == 14));
      end
    end
    bus.start = 1'b0;
    do_reset();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 1'b0;
    bus.pix_ready = 1'b0;
    step();
    test_reset();
    test_streaming();
    test_backpressure();
    test_alternating();
    test_start_busy();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
